// File: rtl/input_cond_pkg.sv
// Shared constants for the input conditioning stage.
// Channel map, debounce defaults and FSM encoding.
package input_cond_pkg;

  localparam int CH_A = 3;
  localparam int CH_B = 2;
  localparam int CH_C = 1;
  localparam int CH_D = 0;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CNT  = 50000;
  localparam int SIM_STABLE_CNT  = 4;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: synchronizer, stability counter, 2-state FSM.
// out only moves after STABLE_CNT consecutive differing samples.
module debounce_chan
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic tgl
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  deb_state_t             state;

  assign s = sync_q[SYNC_STAGES-1];

  // Plain flop chain into the clock domain, no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only once it has held for STABLE_CNT samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      out   <= 1'b0;
      tgl   <= 1'b0;
    end else begin
      tgl <= 1'b0;
      unique case (state)
        ST_STABLE: begin
          if (s != out) begin
            if (STABLE_CNT == 1) begin
              out <= s;
              tgl <= 1'b1;
            end else begin
              state <= ST_PENDING;
              cnt   <= ONE;
            end
          end
        end
        ST_PENDING: begin
          if (s == out) begin
            cnt   <= '0;
            state <= ST_STABLE;
          end else if (cnt == LAST) begin
            out   <= s;
            tgl   <= 1'b1;
            cnt   <= '0;
            state <= ST_STABLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debounce4.sv
// Four independent debounced inputs feeding y = abc + a'c' + d.
// chg pulses for the cycle in which any level first becomes visible.
module input_debounce4
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       chg
);

  logic [3:0] deb;
  logic [3:0] tgl;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .raw(raw_in[i]),
      .out(deb[i]),
      .tgl(tgl[i])
    );
  end

  assign a   = deb[CH_A];
  assign b   = deb[CH_B];
  assign c   = deb[CH_C];
  assign d   = deb[CH_D];
  assign chg = |tgl;

endmodule

// File: tb/tb_input_debounce4.sv
// Bench for input_debounce4: directed scenarios plus random bouncing
// inputs, checked every cycle against a run-length debounce model.
module tb_input_debounce4;
  import input_cond_pkg::*;

  localparam int SYNC = 2;
  localparam int STAB = SIM_STABLE_CNT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] raw_in = 4'h0;
  logic       a, b, c, d, chg;

  int vecs = 0;
  int errs = 0;

  input_debounce4 #(
    .SYNC_STAGES(SYNC),
    .STABLE_CNT (STAB),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_in(raw_in),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .chg   (chg)
  );

  always #5 clk = ~clk;

  // Model: s is raw delayed SYNC samples; a level flips once it has
  // disagreed with the output for STAB consecutive samples.
  logic [3:0] hist [SYNC];
  int         run  [4];
  logic [3:0] m_out = 4'h0;
  logic       m_chg = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] s;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 4'h0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_out = 4'h0;
      m_chg = 1'b0;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw_in;
      m_chg = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_out[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (run[i] == STAB) begin
          m_out[i] = s[i];
          run[i]   = 0;
          m_chg    = 1'b1;
        end
      end
    end
  end

  bit model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      vecs++;
      if ({a, b, c, d, chg} !== {m_out, m_chg}) begin
        errs++;
        $display("FAIL model t=%0t got abcd/chg=%b/%b exp %b/%b",
                 $time, {a, b, c, d}, chg, m_out, m_chg);
      end
    end
  end

  task automatic chk(input string nm, input logic [4:0] exp);
    vecs++;
    if ({a, b, c, d, chg} !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got abcd_chg=%b exp %b",
               nm, $time, {a, b, c, d, chg}, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input logic [3:0] v);
    raw_in = v;
    cyc(12);
  endtask

  initial begin
    int hold [4];
    // 1: reset with all inputs high
    raw_in = 4'hF;
    #1 rst = 1'b1;
    #1 chk("rst_imm", 5'b0000_0);
    cyc(3);
    model_on = 1'b1;
    chk("rst_hold", 5'b0000_0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rst_rel_low", 5'b0000_0);
    end
    cyc(1);
    chk("rst_rel_rise", 5'b1111_1);
    cyc(1);
    chk("rst_rel_post", 5'b1111_0);

    // 2: clean edge on d
    settle(4'h0);
    chk("clean_base", 5'b0000_0);
    raw_in = 4'h1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("clean_wait", 5'b0000_0);
    end
    cyc(1);
    chk("clean_rise", 5'b0001_1);
    cyc(1);
    chk("clean_post", 5'b0001_0);

    // 3: bounce on a
    settle(4'h0);
    for (int k = 0; k < 4; k++) begin
      raw_in[3] = (k % 2 == 0);
      for (int i = 0; i < 2; i++) begin
        cyc(1);
        chk("bounce_tog", 5'b0000_0);
      end
    end
    raw_in[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bounce_wait", 5'b0000_0);
    end
    cyc(1);
    chk("bounce_rise", 5'b1000_1);

    // 4: short glitch on c
    settle(4'h0);
    raw_in[1] = 1'b1;
    cyc(3);
    raw_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("glitch", 5'b0000_0);
      cyc(1);
    end

    // 5: a and c together
    settle(4'h0);
    raw_in = 4'hA;
    cyc(5);
    chk("simul_wait", 5'b0000_0);
    cyc(1);
    chk("simul_rise", 5'b1010_1);
    cyc(1);
    chk("simul_post", 5'b1010_0);

    // 6: reset in the middle of a count
    settle(4'h0);
    raw_in = 4'h4;
    cyc(3);
    #2 rst = 1'b1;
    #1 chk("mid_rst_imm", 5'b0000_0);
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("mid_rst_wait", 5'b0000_0);
    end
    cyc(1);
    chk("mid_rst_rise", 5'b0100_1);

    // random bouncing, occasional async reset
    for (int i = 0; i < 4; i++) hold[i] = 1;
    for (int t = 0; t < 3000; t++) begin
      cyc(1);
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #($urandom_range(1, 8)) rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          raw_in[i] = $urandom_range(0, 1);
          hold[i]   = $urandom_range(1, 9);
        end
      end
    end
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
